// File: rtl/commit_unit_if.sv
// Shared commit types plus the scoreboard-to-commit bus (heads in, acks and
// register-file writes out).
package commit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR, FU_FPU
    } fu_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_JAL, OP_MUL, OP_LW, OP_FLW, OP_SW, OP_FSW,
        OP_AMO_ADD, OP_AMO_SWAP, OP_LR, OP_SC, OP_CSRRW, OP_FADD
    } op_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic            valid;
        fu_t             fu;
        op_t             op;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        exception_t      ex;
    } scoreboard_entry_t;

    function automatic logic is_amo(op_t op);
        return op inside {OP_AMO_ADD, OP_AMO_SWAP, OP_LR, OP_SC};
    endfunction

    function automatic logic is_rd_fpr(op_t op);
        return op inside {OP_FLW, OP_FADD};
    endfunction

endpackage

interface commit_unit_if
    import commit_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2
);
    scoreboard_entry_t [NR_COMMIT_PORTS-1:0]           commit_instr;
    logic              [NR_COMMIT_PORTS-1:0]           commit_ack;
    logic              [NR_COMMIT_PORTS-1:0][4:0]      waddr;
    logic              [NR_COMMIT_PORTS-1:0][XLEN-1:0] wdata;
    logic              [NR_COMMIT_PORTS-1:0]           we_gpr;
    logic              [NR_COMMIT_PORTS-1:0]           we_fpr;

    modport master (output commit_instr, input commit_ack, waddr, wdata, we_gpr, we_fpr);
    modport slave  (input commit_instr, output commit_ack, waddr, wdata, we_gpr, we_fpr);
endinterface

// File: rtl/commit_unit.sv
// In-order commit stage: retires scoreboard heads, writes GPR/FPR, sequences
// store/CSR/AMO handshakes and raises precise exceptions. COMMIT_PERF_CNT_EN adds instret.
module commit_unit
    import commit_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            flush_i,
    input  logic            halt_i,
    commit_unit_if.slave    commit_if,
    output logic            commit_lsu_o,
    input  logic            commit_lsu_ready_i,
    output logic            csr_commit_o,
    input  logic            csr_ack_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            amo_commit_o,
    input  logic            amo_resp_valid_i,
    input  logic [XLEN-1:0] amo_result_i,
    output exception_t      exception_o,
    output logic [63:0]     instret_o
);

    typedef enum logic [1:0] {IDLE, WAIT_CSR, WAIT_AMO, FLUSH} state_e;

    state_e                     state_q, state_d;
    scoreboard_entry_t          head0;
    logic                       commit_en;
    logic                       ack0, retire0;
    logic [XLEN-1:0]            wdata0;
    logic                       head0_pairable;
    logic [NR_COMMIT_PORTS-1:0] ack, retire;

    assign head0     = commit_if.commit_instr[0];
    assign commit_en = !halt_i && !clr_i && head0.valid;

    // Only simple single-cycle classes may share a cycle with a younger head.
    assign head0_pairable = (head0.fu inside {FU_ALU, FU_CTRL_FLOW, FU_MULT})
                         || (head0.fu == FU_LOAD && !is_amo(head0.op));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_ni)     state_q <= IDLE;
        else if (clr_i)  state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        state_d      = state_q;
        ack0         = 1'b0;
        retire0      = 1'b0;
        wdata0       = head0.result;
        commit_lsu_o = 1'b0;
        csr_commit_o = 1'b0;
        amo_commit_o = 1'b0;
        exception_o  = '0;

        unique case (state_q)
            IDLE: if (commit_en) begin
                if (head0.ex.valid) begin
                    ack0        = 1'b1;
                    exception_o = head0.ex;
                    state_d     = FLUSH;
                end else if (head0.fu == FU_STORE && !is_amo(head0.op)) begin
                    commit_lsu_o = 1'b1;
                    ack0         = commit_lsu_ready_i;
                    retire0      = commit_lsu_ready_i;
                end else if (head0.fu == FU_CSR) begin
                    csr_commit_o = 1'b1;
                    state_d      = WAIT_CSR;
                end else if (is_amo(head0.op)) begin
                    amo_commit_o = 1'b1;
                    state_d      = WAIT_AMO;
                end else begin
                    ack0    = 1'b1;
                    retire0 = 1'b1;
                end
            end
            WAIT_CSR: if (commit_en && csr_ack_i) begin
                ack0    = 1'b1;
                retire0 = 1'b1;
                wdata0  = csr_rdata_i;
                state_d = IDLE;
            end
            WAIT_AMO: if (commit_en && amo_resp_valid_i) begin
                ack0    = 1'b1;
                retire0 = 1'b1;
                wdata0  = amo_result_i;
                state_d = IDLE;
            end
            FLUSH: ;
            default: state_d = IDLE;
        endcase

        // A flush abandons any outstanding wait; late responses land in IDLE and are ignored.
        if (flush_i) state_d = IDLE;
    end

    if (NR_COMMIT_PORTS > 1) begin : g_dual
        scoreboard_entry_t head1;
        logic              dual;
        assign head1 = commit_if.commit_instr[1];
        assign dual  = (state_q == IDLE) && retire0 && head0_pairable
                    && head1.valid && !head1.ex.valid
                    && ((head1.fu inside {FU_ALU, FU_MULT})
                        || (head1.fu == FU_LOAD && !is_amo(head1.op)));
        assign ack    = {dual, ack0};
        assign retire = {dual, retire0};
    end else begin : g_single
        assign ack    = ack0;
        assign retire = retire0;
    end

    assign commit_if.commit_ack = ack;

    for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_wr
        assign commit_if.waddr[i]  = commit_if.commit_instr[i].rd;
        assign commit_if.wdata[i]  = (i == 0) ? wdata0 : commit_if.commit_instr[i].result;
        assign commit_if.we_fpr[i] = retire[i] && is_rd_fpr(commit_if.commit_instr[i].op);
        assign commit_if.we_gpr[i] = retire[i] && !is_rd_fpr(commit_if.commit_instr[i].op)
                                  && (commit_if.commit_instr[i].rd != 5'd0);
    end

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] instret_q, instret_d;

    assign instret_d = instret_q + 64'($countones(retire));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     instret_q <= '0;
        else if (clr_i)  instret_q <= '0;
        else             instret_q <= instret_d;
    end

    assign instret_o = instret_q;
`else
    assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios with literal
// expectations, then randomized scoreboard traffic against a behavioural model.
module tb_commit_unit;
    import commit_pkg::*;

    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            rst_n, clr, flush, halt;
    logic            lsu_ready, csr_ack, amo_resp;
    logic [XLEN-1:0] csr_rdata, amo_result;
    logic            commit_lsu, csr_commit, amo_commit;
    exception_t      exc;
    logic [63:0]     instret;

    commit_unit_if #(.NR_COMMIT_PORTS(NP)) cif ();

    commit_unit #(.NR_COMMIT_PORTS(NP)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clr_i              (clr),
        .flush_i            (flush),
        .halt_i             (halt),
        .commit_if          (cif),
        .commit_lsu_o       (commit_lsu),
        .commit_lsu_ready_i (lsu_ready),
        .csr_commit_o       (csr_commit),
        .csr_ack_i          (csr_ack),
        .csr_rdata_i        (csr_rdata),
        .amo_commit_o       (amo_commit),
        .amo_resp_valid_i   (amo_resp),
        .amo_result_i       (amo_result),
        .exception_o        (exc),
        .instret_o          (instret)
    );

    always #5 clk = ~clk;

`ifdef COMMIT_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          chk_en = 1'b0;
    bit          m_wait_csr = 1'b0, m_wait_amo = 1'b0, m_blocked = 1'b0;
    longint unsigned m_instret = 0;
    int          m_pops = 0;

    logic [1:0]      e_ack, e_gpr, e_fpr;
    logic [4:0]      e_waddr [2];
    logic [XLEN-1:0] e_wdata [2];
    logic            e_lsu, e_csr, e_amo, e_exv;
    logic [XLEN-1:0] e_cause;
    int              e_ret;

    function automatic bit m_is_amo(op_t op);
        case (op)
            OP_AMO_ADD, OP_AMO_SWAP, OP_LR, OP_SC: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic bit m_is_fpr(op_t op);
        case (op)
            OP_FLW, OP_FADD: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic bit simple_older(scoreboard_entry_t h);
        return h.fu == FU_ALU || h.fu == FU_CTRL_FLOW || h.fu == FU_MULT
            || (h.fu == FU_LOAD && !m_is_amo(h.op));
    endfunction

    function automatic bit simple_younger(scoreboard_entry_t h);
        return h.valid && !h.ex.valid
            && (h.fu == FU_ALU || h.fu == FU_MULT || (h.fu == FU_LOAD && !m_is_amo(h.op)));
    endfunction

    task automatic model_retire(int p, scoreboard_entry_t h, logic [XLEN-1:0] val);
        e_ack[p]   = 1'b1;
        e_waddr[p] = h.rd;
        e_wdata[p] = val;
        if (m_is_fpr(h.op))   e_fpr[p] = 1'b1;
        else if (h.rd != 0)   e_gpr[p] = 1'b1;
        e_ret++;
    endtask

    task automatic model_eval();
        scoreboard_entry_t h0, h1;
        h0 = cif.commit_instr[0];
        h1 = cif.commit_instr[1];
        e_ack = '0; e_gpr = '0; e_fpr = '0;
        e_lsu = 1'b0; e_csr = 1'b0; e_amo = 1'b0; e_exv = 1'b0; e_cause = '0; e_ret = 0;
        if (clr || halt || !h0.valid || m_blocked) return;
        if (m_wait_csr) begin
            if (csr_ack) model_retire(0, h0, csr_rdata);
        end else if (m_wait_amo) begin
            if (amo_resp) model_retire(0, h0, amo_result);
        end else if (h0.ex.valid) begin
            e_ack[0] = 1'b1;
            e_exv    = 1'b1;
            e_cause  = h0.ex.cause;
        end else if (h0.fu == FU_STORE && !m_is_amo(h0.op)) begin
            e_lsu = 1'b1;
            if (lsu_ready) model_retire(0, h0, h0.result);
        end else if (h0.fu == FU_CSR) begin
            e_csr = 1'b1;
        end else if (m_is_amo(h0.op)) begin
            e_amo = 1'b1;
        end else begin
            model_retire(0, h0, h0.result);
            if (simple_older(h0) && simple_younger(h1)) model_retire(1, h1, h1.result);
        end
    endtask

    task automatic model_update();
        if (clr) begin
            m_wait_csr = 1'b0; m_wait_amo = 1'b0; m_blocked = 1'b0;
            m_instret  = 0;
        end else begin
            m_instret += 64'(e_ret);
            if (e_ack[0]) begin m_wait_csr = 1'b0; m_wait_amo = 1'b0; end
            if (e_exv) m_blocked  = 1'b1;
            if (e_csr) m_wait_csr = 1'b1;
            if (e_amo) m_wait_amo = 1'b1;
            if (flush) begin m_wait_csr = 1'b0; m_wait_amo = 1'b0; m_blocked = 1'b0; end
        end
        m_pops = int'(e_ack[0]) + int'(e_ack[1]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            check("ack", cif.commit_ack, e_ack);
            check("we_gpr", cif.we_gpr, e_gpr);
            check("we_fpr", cif.we_fpr, e_fpr);
            for (int p = 0; p < NP; p++) begin
                if (e_gpr[p] || e_fpr[p]) begin
                    check($sformatf("waddr%0d", p), cif.waddr[p], e_waddr[p]);
                    check($sformatf("wdata%0d", p), cif.wdata[p], e_wdata[p]);
                end
            end
            check("commit_lsu", commit_lsu, e_lsu);
            check("csr_commit", csr_commit, e_csr);
            check("amo_commit", amo_commit, e_amo);
            check("exc_valid", exc.valid, e_exv);
            if (e_exv) check("exc_cause", exc.cause, e_cause);
            check("instret", instret, PERF ? m_instret : 64'd0);
            model_update();
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic scoreboard_entry_t mk(fu_t fu, op_t op, logic [4:0] rd, logic [XLEN-1:0] res);
        scoreboard_entry_t e;
        e        = '0;
        e.valid  = 1'b1;
        e.fu     = fu;
        e.op     = op;
        e.rd     = rd;
        e.result = res;
        return e;
    endfunction

    function automatic scoreboard_entry_t rand_entry();
        scoreboard_entry_t e;
        logic [4:0]        rd;
        logic [XLEN-1:0]   res;
        rd  = 5'($urandom_range(0, 31));
        res = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: e = mk(FU_ALU, OP_ADD, rd, res);
            3:       e = mk(FU_CTRL_FLOW, OP_JAL, rd, res);
            4:       e = mk(FU_MULT, OP_MUL, rd, res);
            5:       e = mk(FU_LOAD, ($urandom_range(0, 2) == 0) ? OP_FLW
                                   : (($urandom_range(0, 3) == 0) ? OP_LR : OP_LW), rd, res);
            6:       e = mk(FU_STORE, $urandom_range(0, 1) ? OP_SW : OP_FSW, 5'd0, res);
            7:       e = mk(FU_STORE, $urandom_range(0, 1) ? OP_AMO_ADD : OP_SC, rd, res);
            8:       e = mk(FU_CSR, OP_CSRRW, rd, res);
            default: e = mk(FU_FPU, OP_FADD, rd, res);
        endcase
        if ($urandom_range(0, 15) == 0) begin
            e.ex.valid = 1'b1;
            e.ex.cause = XLEN'($urandom_range(0, 15));
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    scoreboard_entry_t sb_q[$];
    bit                late_resp = 1'b0;

    initial begin
        rst_n = 1'b0; clr = 1'b0; flush = 1'b0; halt = 1'b0;
        lsu_ready = 1'b0; csr_ack = 1'b0; amo_resp = 1'b0;
        csr_rdata = '0; amo_result = '0;
        cif.commit_instr = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", cif.commit_ack, 2'b00);
        check("rst_lsu", commit_lsu, 1'b0);
        check("rst_csr", csr_commit, 1'b0);
        check("rst_amo", amo_commit, 1'b0);
        check("rst_exc", exc.valid, 1'b0);
        check("rst_instret", instret, 64'd0);
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Two ALU heads retire together
        step();
        cif.commit_instr[0] = mk(FU_ALU, OP_ADD, 5'd5, 32'hA);
        cif.commit_instr[1] = mk(FU_ALU, OP_ADD, 5'd6, 32'hB);
        @(negedge clk);
        check("t1_ack", cif.commit_ack, 2'b11);
        check("t1_we_gpr", cif.we_gpr, 2'b11);
        check("t1_waddr0", cif.waddr[0], 5'd5);
        check("t1_waddr1", cif.waddr[1], 5'd6);
        check("t1_wdata0", cif.wdata[0], 32'hA);
        check("t1_wdata1", cif.wdata[1], 32'hB);
        check("t1_instret0", instret, 64'd0);
        step();
        cif.commit_instr = '0;
        @(negedge clk);
        check("t1_instret2", instret, PERF ? 64'd2 : 64'd0);

        // Store waits for store-buffer ready; younger ALU never pairs with it
        step();
        cif.commit_instr[0] = mk(FU_STORE, OP_SW, 5'd0, 32'h77);
        cif.commit_instr[1] = mk(FU_ALU, OP_ADD, 5'd4, 32'h1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            @(negedge clk);
            check("t2_lsu_wait", commit_lsu, 1'b1);
            check("t2_ack_wait", cif.commit_ack, 2'b00);
        end
        step();
        lsu_ready = 1'b1;
        @(negedge clk);
        check("t2_lsu_go", commit_lsu, 1'b1);
        check("t2_ack_go", cif.commit_ack, 2'b01);
        step();
        lsu_ready = 1'b0;
        cif.commit_instr = '0;

        // CSR request, ack two cycles later
        cif.commit_instr[0] = mk(FU_CSR, OP_CSRRW, 5'd7, 32'h0);
        @(negedge clk);
        check("t3_csr_req", csr_commit, 1'b1);
        check("t3_ack_req", cif.commit_ack, 2'b00);
        step();
        @(negedge clk);
        check("t3_csr_pulse", csr_commit, 1'b0);
        check("t3_ack_wait", cif.commit_ack, 2'b00);
        step();
        csr_ack = 1'b1; csr_rdata = 32'h1234;
        @(negedge clk);
        check("t3_ack", cif.commit_ack, 2'b01);
        check("t3_we_gpr", cif.we_gpr, 2'b01);
        check("t3_waddr", cif.waddr[0], 5'd7);
        check("t3_wdata", cif.wdata[0], 32'h1234);
        step();
        csr_ack = 1'b0;
        cif.commit_instr = '0;

        // Exception blocks commit until flush
        cif.commit_instr[0] = mk(FU_ALU, OP_ADD, 5'd3, 32'h5);
        cif.commit_instr[0].ex.valid = 1'b1;
        cif.commit_instr[0].ex.cause = 32'd2;
        cif.commit_instr[1] = mk(FU_ALU, OP_ADD, 5'd4, 32'h6);
        @(negedge clk);
        check("t4_ack", cif.commit_ack, 2'b01);
        check("t4_exc_valid", exc.valid, 1'b1);
        check("t4_exc_cause", exc.cause, 32'd2);
        check("t4_no_write", cif.we_gpr, 2'b00);
        step();
        cif.commit_instr[0] = mk(FU_ALU, OP_ADD, 5'd4, 32'h6);
        cif.commit_instr[1] = '0;
        repeat (2) begin
            @(negedge clk);
            check("t4_blocked", cif.commit_ack, 2'b00);
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        check("t4_flush_cycle", cif.commit_ack, 2'b00);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t4_resume", cif.commit_ack, 2'b01);
        step();

        // AMO abandoned by flush; late response must not be consumed
        cif.commit_instr[0] = mk(FU_STORE, OP_AMO_ADD, 5'd3, 32'h0);
        @(negedge clk);
        check("t5_amo_req", amo_commit, 1'b1);
        check("t5_ack_req", cif.commit_ack, 2'b00);
        step();
        @(negedge clk);
        check("t5_amo_pulse", amo_commit, 1'b0);
        step();
        cif.commit_instr = '0;
        flush = 1'b1;
        @(negedge clk);
        check("t5_flush_ack", cif.commit_ack, 2'b00);
        step();
        flush = 1'b0;
        amo_resp = 1'b1; amo_result = 32'hDEAD;
        cif.commit_instr[0] = mk(FU_ALU, OP_ADD, 5'd9, 32'h55);
        @(negedge clk);
        check("t5_late_ack", cif.commit_ack, 2'b01);
        check("t5_late_wdata", cif.wdata[0], 32'h55);
        step();
        amo_resp = 1'b0;
        cif.commit_instr = '0;

        // rd=0 suppresses the GPR write; halt blocks everything
        cif.commit_instr[0] = mk(FU_ALU, OP_ADD, 5'd0, 32'hFF);
        @(negedge clk);
        check("t6_ack_rd0", cif.commit_ack, 2'b01);
        check("t6_we_rd0", cif.we_gpr, 2'b00);
        step();
        halt = 1'b1;
        cif.commit_instr[0] = mk(FU_ALU, OP_ADD, 5'd1, 32'h1);
        cif.commit_instr[1] = mk(FU_ALU, OP_ADD, 5'd2, 32'h2);
        @(negedge clk);
        check("t6_halt_ack", cif.commit_ack, 2'b00);
        step();
        halt = 1'b0;

        // Synchronous clear behaves like reset
        clr = 1'b1;
        @(negedge clk);
        check("t7_clr_ack", cif.commit_ack, 2'b00);
        step();
        clr = 1'b0;
        cif.commit_instr = '0;
        @(negedge clk);
        check("t7_clr_instret", instret, 64'd0);

        // Randomized scoreboard traffic
        m_pops = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            for (int k = 0; k < m_pops; k++) if (sb_q.size() > 0) void'(sb_q.pop_front());
            csr_ack = 1'b0; amo_resp = 1'b0; flush = 1'b0; clr = 1'b0; halt = 1'b0;
            csr_rdata  = $urandom;
            amo_result = $urandom;
            lsu_ready  = 1'($urandom_range(0, 1));
            if (late_resp) begin
                csr_ack   = 1'b1;
                amo_resp  = 1'b1;
                late_resp = 1'b0;
            end
            if (m_blocked) begin
                if ($urandom_range(0, 2) == 0) begin flush = 1'b1; sb_q.delete(); end
            end else if (m_wait_csr || m_wait_amo) begin
                int k;
                k = $urandom_range(0, 7);
                if (k < 3) begin
                    if (m_wait_csr) csr_ack = 1'b1;
                    else            amo_resp = 1'b1;
                end else if (k == 3) begin
                    flush = 1'b1;
                    sb_q.delete();
                    late_resp = 1'b1;
                end
            end else begin
                halt = ($urandom_range(0, 9) == 0);
                clr  = ($urandom_range(0, 199) == 0);
            end
            while (sb_q.size() < 4 && $urandom_range(0, 3) != 0) sb_q.push_back(rand_entry());
            cif.commit_instr[0] = (sb_q.size() > 0) ? sb_q[0] : '0;
            cif.commit_instr[1] = (sb_q.size() > 1) ? sb_q[1] : '0;
        end

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- Consumer end of the scoreboard commit interface.
- Takes up to NR_COMMIT_PORTS in-order scoreboard_entry_t heads and returns per-port commit acks.
- Drives architectural register-file writes (GPR/FPR) and sequences stores, CSR and AMO commits with multi-cycle handshakes.
- Raises precise exceptions to the controller and holds commit until the resulting flush.

Parameters:
NR_COMMIT_PORTS, 2, number of scoreboard heads presented per cycle (supported values: 1 or 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clr_i  in  1  synchronous clear, active high; same effect as reset
flush_i  in  1  pipeline flush from controller
halt_i  in  1  block all commits (WFI/debug)
commit_instr_i  in  NR_COMMIT_PORTS x scoreboard_entry_t  in-order scoreboard heads
commit_ack_o  out  NR_COMMIT_PORTS  entry retired this cycle
waddr_o  out  NR_COMMIT_PORTS x 5  register write address
wdata_o  out  NR_COMMIT_PORTS x XLEN  register write data
we_gpr_o  out  NR_COMMIT_PORTS  GPR write enable
we_fpr_o  out  NR_COMMIT_PORTS  FPR write enable
commit_lsu_o  out  1  release oldest speculative store
commit_lsu_ready_i  in  1  store buffer can accept release
csr_commit_o  out  1  one-cycle CSR execute request
csr_ack_i  in  1  CSR done
csr_rdata_i  in  XLEN  CSR read value
amo_commit_o  out  1  one-cycle AMO start request
amo_resp_valid_i  in  1  AMO done
amo_result_i  in  XLEN  AMO load value
exception_o  out  exception_t  exception of retiring head
instret_o  out  64  retired-instruction counter

Behaviour:
- Reset/clr_i:
  - FSM to IDLE; instret_o=0.
  - All outputs 0: ack, we_*, commit_lsu_o, csr_commit_o, amo_commit_o, exception_o.valid.
- Global gating: no commit of any kind while halt_i=1, or in a cycle where port 0 valid=0.
- FSM IDLE, port 0 head, priority order:
  - ex.valid: ack[0]=1, exception_o=entry.ex for this cycle (combinational), no register write, go FLUSH.
  - STORE, non-AMO: commit_lsu_o=1; ack[0]=commit_lsu_ready_i.
  - CSR: csr_commit_o=1 for exactly one cycle, go WAIT_CSR, no ack.
  - AMO (is_amo(op)): amo_commit_o=1 for one cycle, go WAIT_AMO, no ack.
  - Otherwise: ack[0]=1, wdata=result.
- WAIT_CSR: hold; on csr_ack_i, ack[0]=1, wdata[0]=csr_rdata_i, go IDLE.
- WAIT_AMO: hold; on amo_resp_valid_i, ack[0]=1, wdata[0]=amo_result_i, go IDLE.
- FLUSH: no acks; flush_i returns to IDLE.
- flush_i in any state forces IDLE next cycle. A csr_ack_i or amo_resp_valid_i arriving after that is ignored.
- Register writes, on the ack cycle only:
  - we_fpr = is_rd_fpr(op).
  - we_gpr = !is_rd_fpr(op) && rd!=0.
  - waddr = rd.
- Port 1 acks in the same cycle only if all hold:
  - IDLE, port 0 acked without exception;
  - port 0 fu ∈ {ALU, CTRL_FLOW, MULT, LOAD non-AMO};
  - port 1 valid, no exception, fu ∈ {ALU, MULT, LOAD non-AMO}.
- Same rd on both ports: both write; the regfile resolves port 1 as youngest winner.
- Acks are strictly in order: ack[1]=1 implies ack[0]=1.

Optional Feature:
- COMMIT_PERF_CNT_EN defined:
  - instret_o increments by popcount(commit_ack_o & ~exception), wrapping at 2^64.
  - clr_i/reset zero it.
- Not defined: instret_o tied to 0 and no counter flops.

Test Plan:
- Two ALU heads, rd=5/6, result 0xA/0xB, valid both -> ack=2'b11, we_gpr=11, waddr={6,5}, wdata={0xB,0xA} same cycle; instret 0->2 (if COMMIT_PERF_CNT_EN).
- Store head, commit_lsu_ready_i low 3 cycles then high -> commit_lsu_o high 4 cycles, ack[0] only on 4th, ack[1] never.
- CSR head rd=7, csr_ack_i after 2 cycles with rdata 0x1234 -> csr_commit_o one-cycle pulse; ack[0], we_gpr, waddr=7, wdata=0x1234 on ack cycle.
- Port 0 ex.valid cause=2 -> ack=01, exception_o.valid=1 cause=2, no writes; later valid heads not acked until flush_i, then resume.
- AMO head, flush_i during WAIT_AMO, then late amo_resp_valid_i -> IDLE after flush, no ack/write from late response.
- ALU rd=0 with result 0xFF -> ack[0]=1, we_gpr=0; halt_i=1 with valid heads -> ack=00.
